// File: rtl/fpmult_out_stage_if.sv
// Handshake bundle between the FP multiplier datapath, this output stage and its consumer.
// The stage takes the slave view; whoever feeds products and drains results takes the master view.
interface fpmult_out_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic        inexact_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_p;
    logic [4:0]  out_flags;

    modport slave (
        input  in_valid, a, b, p, inexact_in, out_ready,
        output in_ready, out_valid, out_p, out_flags
    );

    modport master (
        output in_valid, a, b, p, inexact_in, out_ready,
        input  in_ready, out_valid, out_p, out_flags
    );
endinterface

// File: rtl/fpmult_out_stage.sv
// FP multiplier output stage: IEEE-754 exception classification, NaN canonicalisation,
// a 2-entry skid buffer toward the consumer, and sticky flag / exception counter status.
module fpmult_out_stage #(
    parameter int          CNT_W = 16,
    parameter logic [31:0] QNAN  = 32'h7FC00000
) (
    input  logic               clk,
    input  logic               rst,
    fpmult_out_stage_if.slave  bus,
    output logic [4:0]         sticky_flags,
    input  logic               clear_sticky,
    output logic [CNT_W-1:0]   exc_count
);

    logic [31:0] opnd [2];
    logic [1:0]  is_zero, is_inf, is_nan, is_snan, is_fin;

    assign opnd[0] = bus.a;
    assign opnd[1] = bus.b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_class
            assign is_zero[gi] = (opnd[gi][30:23] == 8'h00) && (opnd[gi][22:0] == 23'd0);
            assign is_inf[gi]  = (opnd[gi][30:23] == 8'hFF) && (opnd[gi][22:0] == 23'd0);
            assign is_nan[gi]  = (opnd[gi][30:23] == 8'hFF) && (opnd[gi][22:0] != 23'd0);
            assign is_snan[gi] = is_nan[gi] && !opnd[gi][22];
            assign is_fin[gi]  = (opnd[gi][30:23] != 8'hFF);
        end
    endgenerate

    logic        invalid, nanres, ovf, unf, inx;
    logic [31:0] new_p;
    logic [4:0]  new_flags;

    always_comb begin
        invalid   = (is_inf[0] && is_zero[1]) || (is_zero[0] && is_inf[1]) || (|is_snan);
        nanres    = invalid || (|is_nan);
        ovf       = !nanres && (bus.p[30:23] == 8'hFF) && (&is_fin);
        // Denormal operands count as nonzero; an exact tiny result is not an underflow.
        unf       = !nanres && (bus.p[30:23] == 8'h00) && (&(is_fin & ~is_zero)) && bus.inexact_in;
        inx       = !nanres && (bus.inexact_in || ovf);
        new_flags = {invalid, 1'b0, ovf, unf, inx};
        new_p     = nanres ? QNAN : bus.p;
    end

    logic             m_valid_q, m_valid_d;
    logic [31:0]      m_p_q, m_p_d;
    logic [4:0]       m_flags_q, m_flags_d;
    logic             s_valid_q, s_valid_d;
    logic [31:0]      s_p_q, s_p_d;
    logic [4:0]       s_flags_q, s_flags_d;
    logic             in_ready_q, in_ready_d;
    logic [4:0]       sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept, xfer, exc_event;
    logic [4:0]       sticky_base;
    logic [CNT_W-1:0] cnt_base;

    always_comb begin
        m_valid_d = m_valid_q;
        m_p_d     = m_p_q;
        m_flags_d = m_flags_q;
        s_valid_d = s_valid_q;
        s_p_d     = s_p_q;
        s_flags_d = s_flags_q;

        accept = bus.in_valid && in_ready_q;
        xfer   = m_valid_q && bus.out_ready;

        // in_ready is low whenever S holds data, so accept and a full S never coincide.
        if (xfer) begin
            if (s_valid_q) begin
                m_p_d     = s_p_q;
                m_flags_d = s_flags_q;
                s_valid_d = 1'b0;
            end else if (accept) begin
                m_p_d     = new_p;
                m_flags_d = new_flags;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (!m_valid_q) begin
            if (accept) begin
                m_valid_d = 1'b1;
                m_p_d     = new_p;
                m_flags_d = new_flags;
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_p_d     = new_p;
            s_flags_d = new_flags;
        end

        in_ready_d = !s_valid_d;

        exc_event   = m_flags_q[4] || m_flags_q[2] || m_flags_q[1];
        sticky_base = clear_sticky ? 5'd0 : sticky_q;
        cnt_base    = clear_sticky ? '0 : cnt_q;
        sticky_d    = sticky_base;
        cnt_d       = cnt_base;
        if (xfer) begin
            sticky_d = sticky_base | m_flags_q;
            if (exc_event && (cnt_base != {CNT_W{1'b1}})) begin
                cnt_d = cnt_base + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q  <= 1'b0;
            m_p_q      <= 32'd0;
            m_flags_q  <= 5'd0;
            s_valid_q  <= 1'b0;
            s_p_q      <= 32'd0;
            s_flags_q  <= 5'd0;
            in_ready_q <= 1'b1;
            sticky_q   <= 5'd0;
            cnt_q      <= '0;
        end else begin
            m_valid_q  <= m_valid_d;
            m_p_q      <= m_p_d;
            m_flags_q  <= m_flags_d;
            s_valid_q  <= s_valid_d;
            s_p_q      <= s_p_d;
            s_flags_q  <= s_flags_d;
            in_ready_q <= in_ready_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = m_valid_q;
    assign bus.out_p     = m_p_q;
    assign bus.out_flags = m_flags_q;
    assign sticky_flags  = sticky_q;
    assign exc_count     = cnt_q;

endmodule

// File: tb/tb_fpmult_out_stage.sv
// Directed bench for fpmult_out_stage: expected results queued at drive time and
// compared in order as the stage hands them off; a narrow-counter twin checks saturation.
module tb_fpmult_out_stage;

    logic clk = 1'b0;
    logic rst;
    logic clear_sticky;
    logic [4:0]  sticky_flags, sticky_flags2;
    logic [15:0] exc_count;
    logic [3:0]  exc_count2;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] p;
        logic [4:0]  f;
    } exp_t;
    exp_t exp_q [$];

    always #5 clk = ~clk;

    fpmult_out_stage_if bus ();
    fpmult_out_stage_if bus2 ();

    assign bus2.in_valid   = bus.in_valid;
    assign bus2.a          = bus.a;
    assign bus2.b          = bus.b;
    assign bus2.p          = bus.p;
    assign bus2.inexact_in = bus.inexact_in;
    assign bus2.out_ready  = bus.out_ready;

    fpmult_out_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .sticky_flags(sticky_flags), .clear_sticky(clear_sticky), .exc_count(exc_count)
    );

    fpmult_out_stage #(.CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave),
        .sticky_flags(sticky_flags2), .clear_sticky(clear_sticky), .exc_count(exc_count2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, expv);
        end
    endtask

    // Scoreboard side: compare each result on the cycle it is handed to the consumer.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("xfer out_p=%h out_flags=%b exp_p=%h exp_flags=%b",
                         bus.out_p, bus.out_flags, e.p, e.f);
                check("out_p", bus.out_p, e.p);
                check("out_flags", {27'd0, bus.out_flags}, {27'd0, e.f});
                check("twin_out_p", bus2.out_p, bus.out_p);
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                         input logic inx, input logic [31:0] ep, input logic [4:0] ef);
        exp_t e;
        bus.in_valid   = 1'b1;
        bus.a          = a;
        bus.b          = b;
        bus.p          = p;
        bus.inexact_in = inx;
        e.p = ep;
        e.f = ef;
        exp_q.push_back(e);
    endtask

    task automatic wait_accept();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                        input logic inx, input logic [31:0] ep, input logic [4:0] ef);
        drive(a, b, p, inx, ep, ef);
        wait_accept();
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) check("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic clear_pulse();
        clear_sticky = 1'b1;
        @(posedge clk);
        #1;
        clear_sticky = 1'b0;
    endtask

    localparam logic [31:0] QN = 32'h7FC00000;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit took3;
        rst = 1'b1;
        clear_sticky = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = 32'd0;
        bus.b = 32'd0;
        bus.p = 32'd0;
        bus.inexact_in = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_p", bus.out_p, 32'd0);
        check("rst_out_flags", {27'd0, bus.out_flags}, 32'd0);
        check("rst_sticky", {27'd0, sticky_flags}, 32'd0);
        check("rst_exc", {16'd0, exc_count}, 32'd0);

        // Normal product, one-cycle latency.
        bus.out_ready = 1'b1;
        send(32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 32'h40400000, 5'b00000);
        check("latency_out_valid", {31'd0, bus.out_valid}, 32'd1);
        drain();
        check("normal_sticky", {27'd0, sticky_flags}, 32'd0);
        check("normal_exc", {16'd0, exc_count}, 32'd0);

        // Invalid cases and quiet-NaN propagation.
        send(32'h7F800000, 32'h00000000, 32'h12345678, 1'b0, QN, 5'b10000);
        drain();
        check("inv_exc", {16'd0, exc_count}, 32'd1);
        send(32'h7FA00000, 32'h3F800000, 32'h7FA00000, 1'b1, QN, 5'b10000);
        send(32'h7FC00001, 32'h3F800000, 32'h7FC00001, 1'b1, QN, 5'b00000);
        drain();
        check("nan_sticky", {27'd0, sticky_flags}, 32'h10);
        check("nan_exc", {16'd0, exc_count}, 32'd2);

        clear_pulse();
        check("clr_sticky", {27'd0, sticky_flags}, 32'd0);
        check("clr_exc", {16'd0, exc_count}, 32'd0);

        // Overflow, underflow, exact tiny result, plain inexact.
        send(32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b0, 32'h7F800000, 5'b00101);
        send(32'h00800000, 32'h00800000, 32'h00000000, 1'b1, 32'h00000000, 5'b00011);
        send(32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 32'h00000000, 5'b00000);
        send(32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b1, 32'h3F800002, 5'b00001);
        drain();
        check("ovuf_sticky", {27'd0, sticky_flags}, 32'h07);
        check("ovuf_exc", {16'd0, exc_count}, 32'd2);

        // Backpressure: P1 to M, P2 to S, P3 stalls.
        bus.out_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, 32'h40000001, 1'b0, 32'h40000001, 5'b00000);
        check("bp_ready_after_p1", {31'd0, bus.in_ready}, 32'd1);
        send(32'h3F800000, 32'h40400000, 32'h40400002, 1'b0, 32'h40400002, 5'b00000);
        check("bp_ready_after_p2", {31'd0, bus.in_ready}, 32'd0);
        drive(32'h3F800000, 32'h40800000, 32'h40800003, 1'b0, 32'h40800003, 5'b00000);
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_ready", {31'd0, bus.in_ready}, 32'd0);
            check("bp_hold_p", bus.out_p, 32'h40000001);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        took3 = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_consecutive", {31'd0, bus.out_valid}, 32'd1);
            if (bus.in_valid && bus.in_ready) took3 = 1;
            @(posedge clk);
            #1;
            if (took3) bus.in_valid = 1'b0;
        end
        check("bp_p3_taken", {31'd0, took3}, 32'd1);
        drain();

        // Clear colliding with an overflow transfer.
        clear_pulse();
        send(32'h7F800000, 32'h00000000, 32'h00000000, 1'b0, QN, 5'b10000);
        drain();
        check("coll_pre_sticky", {27'd0, sticky_flags}, 32'h10);
        bus.out_ready = 1'b0;
        send(32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b0, 32'h7F800000, 5'b00101);
        clear_sticky = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        clear_sticky = 1'b0;
        check("coll_sticky", {27'd0, sticky_flags}, 32'h05);
        check("coll_exc", {16'd0, exc_count}, 32'd1);

        // Reset with both entries full discards them.
        bus.out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, 32'hAAAA0001, 1'b0, 32'hAAAA0001, 5'b00000);
        send(32'h7F800000, 32'h00000000, 32'hAAAA0002, 1'b0, QN, 5'b10000);
        check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("mid_rst_sticky", {27'd0, sticky_flags}, 32'd0);
        check("mid_rst_exc", {16'd0, exc_count}, 32'd0);
        bus.out_ready = 1'b1;
        send(32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 32'h40400000, 5'b00000);
        check("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        drain();
        check("post_rst_idle", {31'd0, bus.out_valid}, 32'd0);

        // Counter saturation: 20 events into a 16-bit and a 4-bit counter.
        clear_pulse();
        for (int n = 0; n < 20; n++) begin
            send(32'h00000000, 32'hFF800000, 32'h0, 1'b0, QN, 5'b10000);
        end
        drain();
        check("sat_exc16", {16'd0, exc_count}, 32'd20);
        check("sat_exc4", {28'd0, exc_count2}, 32'd15);
        check("sat_sticky4", {27'd0, sticky_flags2}, 32'h10);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
